// File: rtl/makekey_expand_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the Rijndael
// key-expansion engine.
package makekey_expand_pkg;

  localparam logic [3:0] KC4 = 4'd4;
  localparam logic [3:0] KC6 = 4'd6;
  localparam logic [3:0] KC8 = 4'd8;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  localparam int BATCH_SIZE = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Only the three AES key sizes with their matching round counts are legal.
  function automatic logic cfg_valid(input logic [3:0] kc, input logic [3:0] round);
    return ((kc == KC4) || (kc == KC6) || (kc == KC8)) && (round == (kc + 4'd6));
  endfunction

endpackage

// File: rtl/makekey_expand_if.sv
// Request/batch handshake between the key source, the expansion engine and
// the Ke/Kd write stage.
interface makekey_expand_if;

  logic         iStart;
  logic [3:0]   iKC;
  logic [3:0]   iRound;
  logic [255:0] iKey;
  logic         oBusy;
  logic         oDone;
  logic         oWr_start;
  logic [6:0]   oWr_count;
  logic [31:0]  oKEY_1;
  logic [31:0]  oKEY_2;
  logic [31:0]  oKEY_3;
  logic [31:0]  oKEY_4;
  logic         iWr_done;

  modport master (
    output iStart, iKC, iRound, iKey, iWr_done,
    input  oBusy, oDone, oWr_start, oWr_count, oKEY_1, oKEY_2, oKEY_3, oKEY_4
  );

  modport slave (
    input  iStart, iKC, iRound, iKey, iWr_done,
    output oBusy, oDone, oWr_start, oWr_count, oKEY_1, oKEY_2, oKEY_3, oKEY_4
  );

endinterface

// File: rtl/makekey_expand_aes_sbox.sv
// Combinational forward Rijndael S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TABLE[11'd2047 - {din, 3'b000} -: 8];

endmodule

// File: rtl/makekey_expand.sv
// Rijndael key expansion: one word per cycle, handed to the Ke/Kd write stage
// in batches of four with a start/done handshake.
module makekey_expand
  import makekey_expand_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  makekey_expand_if.slave  bus
);

  state_t         state_r;
  state_t         state_s;
  logic [6:0]     idx_r;
  logic [3:0]     mod_r;
  logic [3:0]     kc_r;
  logic [6:0]     last_r;
  logic [255:0]   key_r;
  logic [7:0]     rcon_r;
  logic [31:0]    win_r [8];
  logic [31:0]    batch_r [BATCH_SIZE];
  logic           busy_r;
  logic           done_r;
  logic           wr_start_r;
  logic [6:0]     count_r;

  logic           accept_s;
  logic           is_key_s;
  logic           rot_step_s;
  logic           sub_step_s;
  logic           slot_last_s;
  logic [2:0]     back_sel_s;
  logic [255:0]   key_shift_s;
  logic [31:0]    key_word_s;
  logic [31:0]    prev_s;
  logic [31:0]    back_s;
  logic [31:0]    sbox_in_s;
  logic [31:0]    sub_word_s;
  logic [31:0]    temp_s;
  logic [31:0]    w_new_s;
  logic [6:0]     idx_next_s;
  logic [3:0]     mod_next_s;

  assign accept_s    = bus.iStart && cfg_valid(bus.iKC, bus.iRound);
  assign slot_last_s = (idx_r[1:0] == 2'd3);

  // The window holds the last KC words, newest in slot 0, so W[i-KC] sits at KC-1.
  assign back_sel_s  = 3'(kc_r - 4'd1);
  assign prev_s      = win_r[0];
  assign back_s      = win_r[back_sel_s];
  assign key_shift_s = key_r << {idx_r[2:0], 5'b00000};
  assign key_word_s  = key_shift_s[255:224];

  assign is_key_s    = (idx_r < {3'b000, kc_r});
  assign rot_step_s  = !is_key_s && (mod_r == 4'd0);
  assign sub_step_s  = !is_key_s && (kc_r == KC8) && (mod_r == 4'd4);
  assign sbox_in_s   = rot_step_s ? {prev_s[23:0], prev_s[31:24]} : prev_s;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (sbox_in_s[8*b +: 8]),
      .dout (sub_word_s[8*b +: 8])
    );
  end

  // Word generation: key words first, then the Rijndael recurrence.
  always_comb begin
    temp_s = prev_s;
    if (rot_step_s) begin
      temp_s = sub_word_s ^ {rcon_r, 24'h000000};
    end else if (sub_step_s) begin
      temp_s = sub_word_s;
    end else begin
      temp_s = prev_s;
    end
    w_new_s = is_key_s ? key_word_s : (back_s ^ temp_s);
  end

  // Index advance with the i mod KC wrap counter kept in lockstep.
  always_comb begin
    idx_next_s = idx_r + 7'd1;
    if (mod_r == back_sel_s) begin
      mod_next_s = 4'd0;
    end else begin
      mod_next_s = mod_r + 4'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? GEN : IDLE;
      GEN:     state_s = slot_last_s ? ISSUE : GEN;
      ISSUE:   state_s = WAIT;
      WAIT: begin
        if (bus.iWr_done) begin
          state_s = (idx_r == last_r) ? DONE : GEN;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, batch registers and registered handshake outputs.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      idx_r      <= 7'd0;
      mod_r      <= 4'd0;
      kc_r       <= 4'd0;
      last_r     <= 7'd0;
      key_r      <= 256'd0;
      rcon_r     <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wr_start_r <= 1'b0;
      count_r    <= 7'd0;
      for (int k = 0; k < 8; k++) begin
        win_r[k] <= 32'd0;
      end
      for (int k = 0; k < BATCH_SIZE; k++) begin
        batch_r[k] <= 32'd0;
      end
    end else begin
      busy_r     <= (state_s != IDLE);
      done_r     <= (state_s == DONE);
      wr_start_r <= (state_s == ISSUE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            kc_r   <= bus.iKC;
            key_r  <= bus.iKey;
            last_r <= {1'b0, bus.iRound, 2'b11};
            idx_r  <= 7'd0;
            mod_r  <= 4'd0;
            rcon_r <= RCON_INIT;
          end
        end
        GEN: begin
          win_r[0] <= w_new_s;
          for (int k = 1; k < 8; k++) begin
            win_r[k] <= win_r[k-1];
          end
          batch_r[idx_r[1:0]] <= w_new_s;
          if (rot_step_s) begin
            rcon_r <= xtime(rcon_r);
          end
          // Hold the index on slot 3 so ISSUE and WAIT still see the batch's last word.
          if (slot_last_s) begin
            count_r <= idx_r - 7'd3;
          end else begin
            idx_r <= idx_next_s;
            mod_r <= mod_next_s;
          end
        end
        WAIT: begin
          if (bus.iWr_done && (idx_r != last_r)) begin
            idx_r <= idx_next_s;
            mod_r <= mod_next_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.oBusy     = busy_r;
  assign bus.oDone     = done_r;
  assign bus.oWr_start = wr_start_r;
  assign bus.oWr_count = count_r;
  assign bus.oKEY_1    = batch_r[0];
  assign bus.oKEY_2    = batch_r[1];
  assign bus.oKEY_3    = batch_r[2];
  assign bus.oKEY_4    = batch_r[3];

endmodule

// File: tb/tb_makekey_expand.sv
// Scoreboard bench for makekey_expand: FIPS-197 vectors, random keys, invalid
// configurations, a stretched write-stage response and a mid-run reset.
module tb_makekey_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  makekey_expand_if bus ();

  makekey_expand dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [6:0]   cnt;
    logic [127:0] words;
  } batch_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int wr_starts = 0;
  int delay_batch = -1;
  int delay_extra = 0;
  int ws_cnt = 0;
  batch_t exp_q[$];
  int done_q[$];
  logic [7:0]   sb [256];
  logic [31:0]  model_w [60];
  logic [31:0]  dut_w [64];
  logic [127:0] held = 128'd0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic expand(input int kc, input logic [255:0] key);
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (kc + 7); i++) begin
      if (i < kc) begin
        model_w[i] = key[255 - 32*i -: 32];
      end else begin
        temp = model_w[i-1];
        if (i % kc == 0) begin
          temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (kc == 8 && i % kc == 4) begin
          temp = sub_word(temp);
        end
        model_w[i] = model_w[i-kc] ^ temp;
      end
    end
  endtask

  task automatic push_expect(input int kc, input logic [255:0] key, input int extra);
    batch_t e;
    expand(kc, key);
    for (int b = 0; b < kc + 7; b++) begin
      e.cnt   = 7'(4 * b);
      e.words = {model_w[4*b], model_w[4*b+1], model_w[4*b+2], model_w[4*b+3]};
      exp_q.push_back(e);
    end
    done_q.push_back(9 * (kc + 7) + 1 + extra);
  endtask

  // Write stage: pulses iWr_done four cycles after oWr_start (plus an optional stretch).
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      ws_cnt = 0;
      bus.iWr_done = 1'b0;
    end else begin
      bus.iWr_done = 1'b0;
      if (ws_cnt > 0) begin
        ws_cnt--;
        if (ws_cnt == 0) bus.iWr_done = 1'b1;
      end
      if (bus.oWr_start)
        ws_cnt = 4 + ((int'(bus.oWr_count) == 4 * delay_batch) ? delay_extra : 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a batch or completion.
  always @(negedge clk) begin
    batch_t e;
    if (rst_n === 1'b1) begin
      if (bus.oWr_start) begin
        wr_starts++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr_start: got count %0d expected no batch", bus.oWr_count);
        end else begin
          e = exp_q.pop_front();
          check("wr_count", 128'(bus.oWr_count), 128'(e.cnt));
          check("batch_words", {bus.oKEY_1, bus.oKEY_2, bus.oKEY_3, bus.oKEY_4}, e.words);
        end
        held = {bus.oKEY_1, bus.oKEY_2, bus.oKEY_3, bus.oKEY_4};
        dut_w[bus.oWr_count]      = bus.oKEY_1;
        dut_w[bus.oWr_count + 1]  = bus.oKEY_2;
        dut_w[bus.oWr_count + 2]  = bus.oKEY_3;
        dut_w[bus.oWr_count + 3]  = bus.oKEY_4;
      end
      if (bus.iWr_done)
        check("held_words", {bus.oKEY_1, bus.oKEY_2, bus.oKEY_3, bus.oKEY_4}, held);
      if (bus.oDone) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc - t0);
        end else begin
          check("done_cycle", 128'(cyc - t0), 128'(done_q.pop_front()));
        end
        check("busy_at_done", 128'(bus.oBusy), 128'd1);
      end
    end
  end

  task automatic drive_start(input int kc, input int round, input logic [255:0] key);
    @(posedge clk); #2;
    t0 = cyc;
    bus.iKC = 4'(kc); bus.iRound = 4'(round); bus.iKey = key; bus.iStart = 1'b1;
    @(posedge clk); #2;
    bus.iStart = 1'b0;
  endtask

  task automatic run_key(input int kc, input logic [255:0] key, input int dly_batch,
                         input int dly, input bit poke);
    int ws0;
    bit seen;
    ws0 = wr_starts;
    delay_batch = dly_batch;
    delay_extra = dly;
    push_expect(kc, key, (dly_batch >= 0) ? dly : 0);
    drive_start(kc, kc + 6, key);
    if (poke) begin
      repeat (20) @(posedge clk);
      #2;
      bus.iKC = 4'd4; bus.iRound = 4'd10;
      bus.iKey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.iStart = 1'b1;
      @(posedge clk); #2;
      bus.iStart = 1'b0;
    end
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (bus.oDone) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no oDone expected one within 400 cycles");
    end
    @(negedge clk);
    check("busy_after_done", 128'(bus.oBusy), 128'd0);
    check("batch_count", 128'(wr_starts - ws0), 128'(kc + 7));
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    delay_batch = -1;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"},  128'(bus.oBusy), 128'd0);
    check({tag, "_done"},  128'(bus.oDone), 128'd0);
    check({tag, "_start"}, 128'(bus.oWr_start), 128'd0);
    check({tag, "_count"}, 128'(bus.oWr_count), 128'd0);
    check({tag, "_keys"},  {bus.oKEY_1, bus.oKEY_2, bus.oKEY_3, bus.oKEY_4}, 128'd0);
  endtask

  task automatic invalid_start(input int kc, input int round);
    int ws0, busy_cycles;
    ws0 = wr_starts;
    busy_cycles = 0;
    drive_start(kc, round, KEY128);
    repeat (20) begin
      @(negedge clk);
      if (bus.oBusy) busy_cycles++;
    end
    check("invalid_busy_cycles", 128'(busy_cycles), 128'd0);
    check("invalid_wr_starts", 128'(wr_starts - ws0), 128'd0);
  endtask

  initial begin
    int kc;
    bit hit;
    logic [255:0] rkey;
    bus.iStart = 1'b0; bus.iKC = 4'd0; bus.iRound = 4'd0; bus.iKey = 256'd0;
    build_sbox();
    repeat (3) @(posedge clk);
    #2;
    check_outputs_reset("reset");
    rst_n = 1'b1;

    run_key(4, KEY128, -1, 0, 1'b0);
    check("aes128_w4", 128'(dut_w[4]), 128'h a0fafe17);
    check("aes128_w43", 128'(dut_w[43]), 128'h b6630ca6);

    run_key(6, KEY192, -1, 0, 1'b0);
    check("aes192_w6", 128'(dut_w[6]), 128'h fe0c91f7);
    check("aes192_w51", 128'(dut_w[51]), 128'h 01002202);

    run_key(8, KEY256, -1, 0, 1'b0);
    check("aes256_w8", 128'(dut_w[8]), 128'h 9ba35411);
    check("aes256_w59", 128'(dut_w[59]), 128'h 706c631e);

    invalid_start(5, 11);
    invalid_start(4, 12);

    run_key(4, KEY128, 3, 10, 1'b0);

    for (int r = 0; r < 4; r++) begin
      kc = 4 + 2 * int'($urandom_range(0, 2));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_key(kc, rkey, -1, 0, (r == 1));
    end

    // Reset while batch 5 is being generated, then restart from scratch.
    push_expect(4, KEY128, 0);
    drive_start(4, 10, KEY128);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (bus.oWr_count == 7'd16 && bus.iWr_done) hit = 1'b1;
    end
    check("reached_batch5", 128'(hit), 128'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #2;
    check_outputs_reset("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) dut_w[k] = 32'd0;
    run_key(4, KEY128, -1, 0, 1'b0);
    check("rerun_w4", 128'(dut_w[4]), 128'h a0fafe17);
    check("rerun_w43", 128'(dut_w[43]), 128'h b6630ca6);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
